request_ctrl: RTL and testbench
===============================

REQUEST_CTRL -- requirements
Module: request_ctrl

Interface
REQ-001 Parameter DW, default 32, width of the data-memory load word.
REQ-002 Parameter CNT_W, default 8, width of the wait-cycle counter.
REQ-003 Parameter TIMEOUT, default 255, wait cycles before an access is declared failed; 0 disables the timeout.
REQ-004 Parameter LATCH_LOAD, default 1, enables the registered load-data holding register.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 ihit  in  1  instruction memory access complete this cycle.
REQ-008 dhit  in  1  data memory access complete this cycle.
REQ-009 dREN  in  1  decoded instruction is a load.
REQ-010 dWEN  in  1  decoded instruction is a store.
REQ-011 halt  in  1  decoded instruction is halt.
REQ-012 dmemload  in  DW  data returned by memory.
REQ-013 imemREN  out  1  instruction read request.
REQ-014 dmemREN  out  1  data read request.
REQ-015 dmemWEN  out  1  data write request.
REQ-016 pcEN  out  1  one-cycle PC advance / register-write strobe.
REQ-017 dload_q  out  DW  captured load data.
REQ-018 wait_cnt  out  CNT_W  current wait-cycle count.
REQ-019 halted  out  1  sticky halt indication.
REQ-020 timeout_err  out  1  sticky access-timeout indication.

Function
REQ-021 States SHALL be FETCH, DATA, HALTED, ERROR; state is registered, request outputs and pcEN are decoded from state and current hits.
REQ-022 FETCH: imemREN=1, dmemREN=dmemWEN=0.
REQ-023 FETCH with ihit and halt -> HALTED next cycle; pcEN=0.
REQ-024 FETCH with ihit, no halt, dREN|dWEN -> DATA; pcEN=0; access type latched at transition.
REQ-025 FETCH with ihit, no halt, no memory op: pcEN=1 same cycle, remain FETCH.
REQ-026 DATA: imemREN=0; dmemWEN=latched store; dmemREN=latched load AND NOT latched store (store wins when both set).
REQ-027 DATA with dhit: pcEN=1 same cycle, -> FETCH; if latched load and LATCH_LOAD=1, dload_q <= dmemload on that edge.
REQ-028 dhit in FETCH and ihit in DATA SHALL be ignored.
REQ-029 wait_cnt increments each cycle in FETCH without ihit or in DATA without dhit, saturating at all-ones; clears to 0 on any hit or state change.
REQ-030 If TIMEOUT!=0 and wait_cnt==TIMEOUT with no hit that cycle -> ERROR; a hit in the same cycle takes priority.
REQ-031 HALTED: all requests 0, pcEN 0, halted=1; exit only by reset.
REQ-032 ERROR: all requests 0, pcEN 0, timeout_err=1; exit only by reset.
REQ-033 pcEN SHALL never be high for two consecutive cycles on one instruction.
REQ-034 dload_q holds its value outside REQ-027 captures; constant 0 when LATCH_LOAD=0.

Reset
REQ-035 nRST low SHALL immediately force state FETCH, wait_cnt=0, dload_q=0, latched access type=0, halted=0, timeout_err=0.
REQ-036 Output values during reset: imemREN=1, dmemREN=0, dmemWEN=0, pcEN=0.
REQ-037 Reset asserted mid-DATA SHALL abandon the access with no pcEN pulse and no dload_q update.

Structure
REQ-038 State enum reqst_t (FETCH, DATA, HALTED, ERROR) SHALL live in cpu_types_pkg.
REQ-039 Single module, no sub-modules; counter and holding register inline.

Verification
REQ-040 Reset then ihit=1, no mem op, 3 cycles -> pcEN=1 each ihit cycle, imemREN=1, state FETCH.
REQ-041 ihit with dREN=1, 2 idle cycles, dhit with dmemload=0xDEADBEEF -> dmemREN=1 for 3 cycles, single pcEN on dhit, dload_q=0xDEADBEEF next cycle.
REQ-042 ihit with dREN=1,dWEN=1 -> dmemWEN=1, dmemREN=0, dload_q unchanged after dhit.
REQ-043 TIMEOUT=4, no ihit -> wait_cnt 1..4, ERROR after 5th cycle, timeout_err=1, all requests 0 until reset; ihit on the 5th cycle instead -> no error.
REQ-044 ihit with halt=1 -> halted=1 next cycle, requests 0; further ihit/dhit ignored.
REQ-045 nRST pulsed during DATA -> immediate FETCH, imemREN=1, no pcEN, dload_q=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared request-controller state encoding and counter helper
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } reqst_t;

  localparam int DEF_DW      = 32;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 255;

  function automatic logic is_active(input reqst_t s);
    return (s == FETCH) || (s == DATA);
  endfunction

endpackage

// File: rtl/request_ctrl.sv
// request_ctrl: sequences instruction fetch and data access requests for a single-cycle-style core
module request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int LATCH_LOAD = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic [DW-1:0]    dmemload,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pcEN,
  output logic [DW-1:0]    dload_q,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             halted,
  output logic             timeout_err
);

  reqst_t           r_state;
  reqst_t           w_next;
  logic             r_ld;
  logic             r_st;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_next;
  logic             w_hit;
  logic             w_pc;
  logic             w_to;
  logic             w_enter_data;
  logic             w_capture;

  // the timeout fires only when the count has reached the limit and nothing completed this cycle
  assign w_to = (TIMEOUT != 0) && (r_wait == CNT_W'(TIMEOUT));

  // next-state and request decode from registered state and the hit relevant to that state
  always_comb begin
    w_next  = r_state;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    w_pc    = 1'b0;
    w_hit   = 1'b0;
    case (r_state)
      FETCH: begin
        imemREN = 1'b1;
        w_hit   = ihit;
        if (ihit) begin
          if (halt) w_next = HALTED;
          else if (dREN || dWEN) w_next = DATA;
          else w_pc = 1'b1;
        end else if (w_to) begin
          w_next = ERROR;
        end
      end
      DATA: begin
        dmemWEN = r_st;
        dmemREN = r_ld & ~r_st;
        w_hit   = dhit;
        if (dhit) begin
          w_pc   = 1'b1;
          w_next = FETCH;
        end else if (w_to) begin
          w_next = ERROR;
        end
      end
      default: ;
    endcase
  end

  // a strobe must never leak out while reset is held, even if a hit is presented
  assign pcEN = w_pc & nRST;

  assign w_enter_data = (r_state == FETCH) && (w_next == DATA);
  assign w_capture    = (r_state == DATA) && dhit && r_ld && !r_st;

  // wait counter clears on any completion or state change and saturates instead of wrapping
  assign w_wait_next = (w_hit || (w_next != r_state)) ? '0 :
                       !is_active(r_state)            ? r_wait :
                       (&r_wait)                      ? r_wait :
                                                        r_wait + CNT_W'(1);

  // state, wait count and latched access type
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_enter_data) begin
        r_ld <= dREN;
        r_st <= dWEN;
      end
    end
  end

  generate
    if (LATCH_LOAD != 0) begin : g_latch
      logic [DW-1:0] r_dload;
      // hold the load word returned on the completing data cycle of a pure load
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_dload <= '0;
        else if (w_capture) r_dload <= dmemload;
      end
      assign dload_q = r_dload;
    end else begin : g_nolatch
      assign dload_q = '0;
    end
  endgenerate

  assign wait_cnt    = r_wait;
  assign halted      = (r_state == HALTED);
  assign timeout_err = (r_state == ERROR);

endmodule

// File: tb/tb_request_ctrl.sv
// tb_request_ctrl: table-driven scoreboard bench for request_ctrl
module tb_request_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] dmemload = '0;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pcEN;
  logic [31:0] dload_q;
  logic [7:0]  wait_cnt;
  logic        halted;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rs;
    logic        ih;
    logic        dh;
    logic        rd;
    logic        wr;
    logic        hl;
    logic [31:0] dml;
    logic [5:0]  o;
    logic [7:0]  wc;
    logic [31:0] dq;
  } row_t;

  logic [45:0] exp_q[$];
  wire  [45:0] w_obs = {imemREN, dmemREN, dmemWEN, pcEN, halted, timeout_err, wait_cnt, dload_q};

  request_ctrl #(.DW(32), .CNT_W(8), .TIMEOUT(4), .LATCH_LOAD(1)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .halt(halt), .dmemload(dmemload), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pcEN(pcEN), .dload_q(dload_q), .wait_cnt(wait_cnt),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic row_t mk(input logic rs, input logic ih, input logic dh, input logic rd,
                              input logic wr, input logic hl, input logic [31:0] dml,
                              input logic [5:0] o, input logic [7:0] wc, input logic [31:0] dq);
    return '{rs: rs, ih: ih, dh: dh, rd: rd, wr: wr, hl: hl, dml: dml, o: o, wc: wc, dq: dq};
  endfunction

  task automatic apply(input row_t r);
    nRST     = ~r.rs;
    ihit     = r.ih;
    dhit     = r.dh;
    dREN     = r.rd;
    dWEN     = r.wr;
    halt     = r.hl;
    dmemload = r.dml;
    exp_q.push_back({r.o, r.wc, r.dq});
  endtask

  // o = {imemREN, dmemREN, dmemWEN, pcEN, halted, timeout_err}
  task automatic test_reset();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(1,1,0,0,0,0,0,6'b100000,0,0),
          mk(0,1,0,0,0,0,0,6'b100100,0,0)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL reset row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_fetch();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,1,0,0,0,0,0,6'b100100,0,0),
          mk(0,1,0,0,0,0,0,6'b100100,0,0),
          mk(0,0,0,0,0,0,0,6'b100000,0,0),
          mk(0,1,0,0,0,0,0,6'b100100,1,0)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL fetch row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_load();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,1,0,1,0,0,0,6'b100000,0,0),
          mk(0,1,0,0,0,0,0,6'b010000,0,0),
          mk(0,0,0,0,0,0,0,6'b010000,1,0),
          mk(0,0,1,0,0,0,32'hDEADBEEF,6'b010100,2,0),
          mk(0,0,0,0,0,0,0,6'b100000,0,32'hDEADBEEF),
          mk(0,1,0,0,0,0,0,6'b100100,1,32'hDEADBEEF)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL load row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_store();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,1,0,1,1,0,0,6'b100000,0,32'hDEADBEEF),
          mk(0,0,1,0,0,0,32'h12345678,6'b001100,0,32'hDEADBEEF),
          mk(0,0,1,0,0,0,32'h12345678,6'b100000,0,32'hDEADBEEF),
          mk(0,1,0,0,0,0,0,6'b100100,1,32'hDEADBEEF)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL store row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_timeout();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,0,0,0,0,0,0,6'b100000,0,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,1,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,2,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,3,32'hDEADBEEF),
          mk(0,1,0,0,0,0,0,6'b100100,4,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,0,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,1,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,2,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,3,32'hDEADBEEF),
          mk(0,0,0,0,0,0,0,6'b100000,4,32'hDEADBEEF),
          mk(0,1,1,1,0,0,0,6'b000001,0,32'hDEADBEEF),
          mk(0,1,1,1,0,0,0,6'b000001,0,32'hDEADBEEF),
          mk(1,0,0,0,0,0,0,6'b100000,0,0)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL timeout row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_halt();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,1,0,1,0,1,0,6'b100000,0,0),
          mk(0,1,1,0,0,0,0,6'b000010,0,0),
          mk(0,1,1,1,1,0,32'h55AA55AA,6'b000010,0,0),
          mk(1,0,0,0,0,0,0,6'b100000,0,0)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL halt row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  task automatic test_reset_mid_data();
    row_t r[$];
    logic [45:0] e;
    r = '{mk(0,1,0,1,0,0,0,6'b100000,0,0),
          mk(0,0,1,0,0,0,32'hA5A5A5A5,6'b010100,0,0),
          mk(0,1,0,1,0,0,0,6'b100000,0,32'hA5A5A5A5),
          mk(0,0,0,0,0,0,0,6'b010000,0,32'hA5A5A5A5),
          mk(1,1,1,0,0,0,32'hCAFEF00D,6'b100000,0,0),
          mk(0,1,0,0,0,0,0,6'b100100,0,0)};
    foreach (r[i]) begin
      @(negedge CLK); apply(r[i]); #1;
      e = exp_q.pop_front(); checks++;
      if (w_obs !== e) begin errors++; $display("FAIL mid_reset row %0d got %h exp %h", i, w_obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_halt();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
